// File: rtl/me_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : me_pkg
//  Description : Shared constants and types for the motion-estimator
//                residual generator (block geometry, MV and residual types,
//                residual FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package me_pkg;

    localparam int BLK         = 16;
    localparam int SW          = 32;
    localparam int MV_OFF      = 8;
    localparam int PIX_PER_BLK = 256;

    typedef logic signed [3:0] mv_t;
    typedef logic signed [8:0] residual_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_CAPT = 3'd2,
        S_HOLD = 3'd3,
        S_FIN  = 3'd4
    } res_state_e;

endpackage
`default_nettype wire

// File: rtl/me_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : me_addr_gen
//  Description : Combinational mapping of block row/col plus motion vector
//                onto reference-block and search-window memory addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module me_addr_gen
    import me_pkg::*;
#(
    parameter int BLK    = 16,
    parameter int SW     = 32,
    parameter int MV_OFF = 8
) (
    input  logic [3:0] row,
    input  logic [3:0] col,
    input  mv_t        mv_x,
    input  mv_t        mv_y,
    output logic [7:0] address_ref,
    output logic [9:0] address_search
);

    logic [9:0] row_s;
    logic [9:0] col_s;

    // Search coordinates: block position shifted by the zero-vector offset
    // and the sign-extended MV; the MV range keeps the result inside 0..990.
    assign row_s = {6'd0, row} + 10'(MV_OFF) + {{6{mv_y[3]}}, mv_y};
    assign col_s = {6'd0, col} + 10'(MV_OFF) + {{6{mv_x[3]}}, mv_x};

    assign address_ref    = 8'(row) * 8'(BLK) + 8'(col);
    assign address_search = row_s * 10'(SW) + col_s;

endmodule
`default_nettype wire

// File: rtl/me_residual_gen.sv
`default_nettype none
// ============================================================================
//  Module      : me_residual_gen
//  Description : Re-reads the reference block and the best-matching search
//                block after the estimator completes, streams 256 signed
//                residuals over valid/ready and cross-checks the SAD.
//  Revision    : 1.0 - initial release
// ============================================================================
module me_residual_gen
    import me_pkg::*;
#(
    parameter int BLK    = 16,
    parameter int SW     = 32,
    parameter int MV_OFF = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       completed,
    input  logic [3:0] motion_vector_x,
    input  logic [3:0] motion_vector_y,
    input  logic [7:0] best_distance,
    output logic [7:0] address_ref,
    input  logic [7:0] ref_data,
    output logic [9:0] address_search,
    input  logic [7:0] search_data,
    output logic [8:0] residual_data,
    output logic       residual_valid,
    input  logic       residual_ready,
    output logic       residual_last,
    output logic       busy,
    output logic       done,
    output logic       sad_err
);

    res_state_e state;
    logic       prev_completed;
    mv_t        mv_x;
    mv_t        mv_y;
    logic [7:0] bd;
    logic [7:0] cnt;
    logic [15:0] acc;

    logic       trigger;
    logic [7:0] gen_cnt;
    mv_t        gen_mv_x;
    mv_t        gen_mv_y;
    logic [7:0] gen_ref;
    logic [9:0] gen_search;
    residual_t  diff;
    logic [7:0] abs_diff;
    logic       last_pix;
    logic       sad_mismatch;

    assign trigger  = completed & ~prev_completed;
    assign last_pix = (cnt == 8'(PIX_PER_BLK - 1));

    // Addresses are loaded on entry to READ: pixel 0 with the incoming MV at
    // the trigger, otherwise the next pixel with the captured MV.
    assign gen_cnt  = (state == S_IDLE) ? 8'd0 : cnt + 8'd1;
    assign gen_mv_x = (state == S_IDLE) ? mv_t'(motion_vector_x) : mv_x;
    assign gen_mv_y = (state == S_IDLE) ? mv_t'(motion_vector_y) : mv_y;

    me_addr_gen #(
        .BLK    (BLK),
        .SW     (SW),
        .MV_OFF (MV_OFF)
    ) u_addr_gen (
        .row            (gen_cnt[7:4]),
        .col            (gen_cnt[3:0]),
        .mv_x           (gen_mv_x),
        .mv_y           (gen_mv_y),
        .address_ref    (gen_ref),
        .address_search (gen_search)
    );

    assign diff     = residual_t'({1'b0, ref_data}) - residual_t'({1'b0, search_data});
    assign abs_diff = diff[8] ? 8'(-diff) : 8'(diff);

    // A saturated estimator SAD only claims "at least 255".
    assign sad_mismatch = (bd != 8'hFF) ? (acc != {8'h00, bd}) : (acc < 16'd255);

    assign busy = (state != S_IDLE);

    // Residual FSM: address issue, capture, handshake hold and completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            prev_completed <= 1'b0;
            mv_x           <= '0;
            mv_y           <= '0;
            bd             <= '0;
            cnt            <= '0;
            acc            <= '0;
            address_ref    <= '0;
            address_search <= '0;
            residual_data  <= '0;
            residual_valid <= 1'b0;
            residual_last  <= 1'b0;
            done           <= 1'b0;
            sad_err        <= 1'b0;
        end else begin
            prev_completed <= completed;
            done           <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        mv_x           <= mv_t'(motion_vector_x);
                        mv_y           <= mv_t'(motion_vector_y);
                        bd             <= best_distance;
                        cnt            <= '0;
                        acc            <= '0;
                        sad_err        <= 1'b0;
                        address_ref    <= gen_ref;
                        address_search <= gen_search;
                        state          <= S_READ;
                    end
                end
                S_READ: begin
                    state <= S_CAPT;
                end
                S_CAPT: begin
                    residual_data  <= diff;
                    acc            <= acc + 16'(abs_diff);
                    residual_last  <= last_pix;
                    residual_valid <= 1'b1;
                    state          <= S_HOLD;
                end
                S_HOLD: begin
                    if (residual_ready) begin
                        residual_valid <= 1'b0;
                        residual_last  <= 1'b0;
                        if (last_pix) begin
                            done    <= 1'b1;
                            sad_err <= sad_mismatch;
                            state   <= S_FIN;
                        end else begin
                            cnt            <= cnt + 8'd1;
                            address_ref    <= gen_ref;
                            address_search <= gen_search;
                            state          <= S_READ;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_me_residual_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_me_residual_gen
//  Description : Self-checking bench for me_residual_gen with behavioural
//                memories and a pixel-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_me_residual_gen;

    logic       clk;
    logic       rst_n;
    logic       completed;
    logic [3:0] motion_vector_x;
    logic [3:0] motion_vector_y;
    logic [7:0] best_distance;
    logic [7:0] address_ref;
    logic [7:0] ref_data;
    logic [9:0] address_search;
    logic [7:0] search_data;
    logic [8:0] residual_data;
    logic       residual_valid;
    logic       residual_ready;
    logic       residual_last;
    logic       busy;
    logic       done;
    logic       sad_err;

    logic [7:0] ref_mem    [256];
    logic [7:0] search_mem [1024];

    int n_checks = 0;
    int n_errors = 0;

    me_residual_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .completed       (completed),
        .motion_vector_x (motion_vector_x),
        .motion_vector_y (motion_vector_y),
        .best_distance   (best_distance),
        .address_ref     (address_ref),
        .ref_data        (ref_data),
        .address_search  (address_search),
        .search_data     (search_data),
        .residual_data   (residual_data),
        .residual_valid  (residual_valid),
        .residual_ready  (residual_ready),
        .residual_last   (residual_last),
        .busy            (busy),
        .done            (done),
        .sad_err         (sad_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered memories: data appears one cycle after its address.
    always @(posedge clk) begin
        ref_data    <= ref_mem[address_ref];
        search_data <= search_mem[address_search];
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Search-window address of block pixel k for vector (mvx, mvy).
    function automatic int sa(input int k, input int mvx, input int mvy);
        return (k / 16 + 8 + mvy) * 32 + (k % 16) + 8 + mvx;
    endfunction

    function automatic int model_sad(input int mvx, input int mvy);
        int s = 0;
        for (int k = 0; k < 256; k++) begin
            int d = int'(ref_mem[k]) - int'(search_mem[sa(k, mvx, mvy)]);
            s += (d < 0) ? -d : d;
        end
        return s;
    endfunction

    task automatic fill_search_random();
        for (int i = 0; i < 1024; i++) search_mem[i] = 8'($urandom);
    endtask

    task automatic copy_ref(input int mvx, input int mvy);
        for (int k = 0; k < 256; k++) ref_mem[k] = search_mem[sa(k, mvx, mvy)];
    endtask

    // One job: trigger, consume the stream against the model, check done/sad_err.
    // abort_at >= 0 asserts reset during HOLD of that pixel instead of finishing.
    task automatic run_job(input int mvx, input int mvy, input logic [7:0] bd,
                           input bit rnd, input bit inject, input bit hold_c,
                           input int abort_at);
        int         k;
        int         cyc;
        int         sad;
        int         e;
        bit         first_seen;
        bit         prev_stall;
        bit         hs;
        bit         exp_err;
        logic [8:0] prev_data;
        logic [8:0] exp9;

        sad     = model_sad(mvx, mvy);
        exp_err = (bd != 8'hFF) ? (sad != int'(bd)) : (sad < 255);

        motion_vector_x = 4'(mvx);
        motion_vector_y = 4'(mvy);
        best_distance   = bd;
        residual_ready  = 1'b1;
        @(negedge clk);
        completed = 1'b1;
        @(posedge clk);

        k          = 0;
        cyc        = 0;
        first_seen = 0;
        prev_stall = 0;
        prev_data  = '0;
        while (k < 256 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            completed = hold_c || (inject && k >= 50 && k < 60);
            if (!first_seen && residual_valid) begin
                first_seen = 1;
                chk("first_valid_latency", cyc, 3);
            end
            if (prev_stall) begin
                chk("stall_valid", {31'd0, residual_valid}, 1);
                chk("stall_data", {23'd0, residual_data}, {23'd0, prev_data});
            end
            if (residual_valid) begin
                if (k == abort_at) begin
                    rst_n = 1'b0;
                    @(posedge clk);
                    @(negedge clk);
                    chk("rst_valid", {31'd0, residual_valid}, 0);
                    chk("rst_busy", {31'd0, busy}, 0);
                    chk("rst_addr_ref", {24'd0, address_ref}, 0);
                    chk("rst_addr_search", {22'd0, address_search}, 0);
                    chk("rst_residual", {23'd0, residual_data}, 0);
                    rst_n = 1'b1;
                    completed = 1'b0;
                    repeat (3) @(negedge clk);
                    chk("rst_stays_idle", {31'd0, busy}, 0);
                    return;
                end
                e    = int'(ref_mem[k]) - int'(search_mem[sa(k, mvx, mvy)]);
                exp9 = 9'(e);
                chk("residual", {23'd0, residual_data}, {23'd0, exp9});
                chk("last", {31'd0, residual_last}, {31'd0, (k == 255)});
                chk("addr_ref", {24'd0, address_ref}, k);
                chk("addr_search", {22'd0, address_search}, sa(k, mvx, mvy));
            end
            chk("busy_in_job", {31'd0, busy}, 1);
            residual_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            prev_stall     = residual_valid && !residual_ready;
            prev_data      = residual_data;
            hs             = residual_valid && residual_ready;
            @(posedge clk);
            if (hs) k++;
        end
        residual_ready = 1'b1;
        if (k < 256) begin
            chk("handshake_timeout", k, 256);
            return;
        end
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 1);
        chk("sad_err_at_done", {31'd0, sad_err}, {31'd0, exp_err});
        chk("valid_after_last", {31'd0, residual_valid}, 0);
        @(negedge clk);
        chk("done_cleared", {31'd0, done}, 0);
        chk("busy_cleared", {31'd0, busy}, 0);
        chk("sad_err_held", {31'd0, sad_err}, {31'd0, exp_err});
    endtask

    initial begin
        int sad;

        rst_n           = 1'b0;
        completed       = 1'b0;
        motion_vector_x = '0;
        motion_vector_y = '0;
        best_distance   = '0;
        residual_ready  = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        for (int i = 0; i < 1024; i++) search_mem[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_valid", {31'd0, residual_valid}, 0);
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_sad_err", {31'd0, sad_err}, 0);
        chk("reset_addr_ref", {24'd0, address_ref}, 0);
        chk("reset_addr_search", {22'd0, address_search}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero vector, exact copy: all residuals 0, SAD 0
        fill_search_random();
        copy_ref(0, 0);
        run_job(0, 0, 8'd0, 0, 0, 0, -1);

        // Extreme vectors with random reference data
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        run_job(-8, -8, 8'hFF, 0, 0, 0, -1);
        sad = model_sad(7, 7);
        run_job(7, 7, 8'(sad), 0, 0, 0, -1);

        // Maximum residual magnitude everywhere, saturated estimator SAD
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 1024; i++) search_mem[i] = 8'hFF;
        run_job(3, -5, 8'hFF, 0, 0, 0, -1);

        // True SAD 4 against reported 5: mismatch flagged and held in IDLE
        fill_search_random();
        copy_ref(2, -3);
        for (int j = 0; j < 4; j++) begin
            int p = 37 * j + 11;
            ref_mem[p] = (ref_mem[p] == 8'hFF) ? 8'hFE : ref_mem[p] + 8'd1;
        end
        run_job(2, -3, 8'd5, 0, 0, 0, -1);
        repeat (4) @(negedge clk);
        chk("sad_err_idle_hold", {31'd0, sad_err}, 1);

        // Random backpressure plus an ignored mid-job trigger edge
        fill_search_random();
        copy_ref(-4, 6);
        ref_mem[200] = ref_mem[200] ^ 8'h01;
        run_job(-4, 6, 8'd1, 1, 1, 0, -1);

        // Random vector with random backpressure, reset during pixel 100
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        run_job(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                8'hFF, 1, 0, 0, 100);

        // Fresh job after reset restarts at pixel 0; trigger left high afterwards
        run_job(5, -1, 8'hFF, 1, 0, 1, -1);
        repeat (5) @(negedge clk);
        chk("no_retrigger_on_level", {31'd0, busy}, 0);
        completed = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
